// File: rtl/mul13_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul13_pkg
//  Brief    : Geometry of the 13x13 partial-product array and its reduction.
//  Revision : 1.0
// ============================================================================
package mul13_pkg;

   localparam int N       = 13;
   localparam int COLS    = 2 * N - 1;
   localparam int OUT_W   = 27;
   localparam int PP_BITS = N * N;

   function automatic int col_height(input int i);
      return (i < N) ? i + 1 : 2 * N - 1 - i;
   endfunction

   function automatic int col_offset(input int i);
      int s;
      s = 0;
      for (int j = 0; j < i; j++) s += col_height(j);
      return s;
   endfunction

   // Each column is reduced with floor((n-1)/2) full adders, n = own bits + incoming carries
   function automatic int col_fa_count(input int i);
      int f;
      int n;
      f = 0;
      for (int j = 0; j <= i; j++) begin
         n = col_height(j) + f;
         f = (n > 2) ? (n - 1) / 2 : 0;
      end
      return f;
   endfunction

   function automatic int col_carry_in(input int i);
      return (i == 0) ? 0 : col_fa_count(i - 1);
   endfunction

   function automatic int col_carry_offset(input int i);
      int s;
      s = 0;
      for (int j = 0; j < i; j++) s += col_fa_count(j);
      return s;
   endfunction

   localparam int TOTAL_FA = col_carry_offset(COLS);

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Brief    : 3:2 counter cell of the reduction tree.
//  Revision : 1.0
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/mul13_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : mul13_compressor
//  Brief    : Two-stage compressor: 3:2 tree to carry-save rows, then CPA.
//  Revision : 1.0
// ============================================================================
module mul13_compressor
   import mul13_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        src0,
   input  logic [1:0]  src1,
   input  logic [2:0]  src2,
   input  logic [3:0]  src3,
   input  logic [4:0]  src4,
   input  logic [5:0]  src5,
   input  logic [6:0]  src6,
   input  logic [7:0]  src7,
   input  logic [8:0]  src8,
   input  logic [9:0]  src9,
   input  logic [10:0] src10,
   input  logic [11:0] src11,
   input  logic [12:0] src12,
   input  logic [11:0] src13,
   input  logic [10:0] src14,
   input  logic [9:0]  src15,
   input  logic [8:0]  src16,
   input  logic [7:0]  src17,
   input  logic [6:0]  src18,
   input  logic [5:0]  src19,
   input  logic [4:0]  src20,
   input  logic [3:0]  src21,
   input  logic [2:0]  src22,
   input  logic [1:0]  src23,
   input  logic        src24,
   output logic dst0,  output logic dst1,  output logic dst2,  output logic dst3,
   output logic dst4,  output logic dst5,  output logic dst6,  output logic dst7,
   output logic dst8,  output logic dst9,  output logic dst10, output logic dst11,
   output logic dst12, output logic dst13, output logic dst14, output logic dst15,
   output logic dst16, output logic dst17, output logic dst18, output logic dst19,
   output logic dst20, output logic dst21, output logic dst22, output logic dst23,
   output logic dst24, output logic dst25, output logic dst26
);

   logic [PP_BITS-1:0]  w_pp;
   logic [TOTAL_FA-1:0] w_carry;
   logic [OUT_W-1:0]    w_row_a;
   logic [OUT_W-1:0]    w_row_b;
   logic [OUT_W-1:0]    r_row_a;
   logic [OUT_W-1:0]    r_row_b;
   logic [OUT_W-1:0]    r_sum;

   assign w_pp = {src24, src23, src22, src21, src20, src19, src18, src17, src16,
                  src15, src14, src13, src12, src11, src10, src9,  src8,  src7,
                  src6,  src5,  src4,  src3,  src2,  src1,  src0};

   // Per column, bits form a queue: each FA pops three and pushes its sum to the tail,
   // so the tree is balanced and whatever remains (1 or 2 bits) forms the two rows.
   for (genvar i = 0; i < COLS; i++) begin : g_col
      localparam int H    = col_height(i);
      localparam int CIN  = col_carry_in(i);
      localparam int NIN  = H + CIN;
      localparam int NFA  = col_fa_count(i);
      localparam int NB   = NIN + NFA;
      localparam int LEFT = NIN - 2 * NFA;

      logic [NB-1:0] w_bits;

      assign w_bits[H-1:0] = w_pp[col_offset(i) +: H];

      if (CIN > 0) begin : g_cin
         assign w_bits[NIN-1:H] = w_carry[col_carry_offset(i - 1) +: CIN];
      end

      for (genvar k = 0; k < NFA; k++) begin : g_fa
         full_adder u_fa (
            .a    (w_bits[3*k]),
            .b    (w_bits[3*k+1]),
            .cin  (w_bits[3*k+2]),
            .s    (w_bits[NIN+k]),
            .cout (w_carry[col_carry_offset(i) + k])
         );
      end

      assign w_row_a[i] = w_bits[3*NFA];
      if (LEFT == 2) begin : g_two
         assign w_row_b[i] = w_bits[3*NFA+1];
      end else begin : g_one
         assign w_row_b[i] = 1'b0;
      end
   end

   assign w_row_a[OUT_W-1:COLS] = '0;
   assign w_row_b[OUT_W-1:COLS] = '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_a <= '0;
         r_row_b <= '0;
         r_sum   <= '0;
      end else begin
         r_row_a <= w_row_a;
         r_row_b <= w_row_b;
         r_sum   <= r_row_a + r_row_b;
      end
   end

   assign {dst26, dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18,
           dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,
           dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_mul13_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul13_compressor
//  Brief    : Randomized self-checking bench against a popcount / product model.
//  Revision : 1.0
// ============================================================================
module tb_mul13_compressor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [168:0] pp = '0;

   logic        src0;
   logic [1:0]  src1;
   logic [2:0]  src2;
   logic [3:0]  src3;
   logic [4:0]  src4;
   logic [5:0]  src5;
   logic [6:0]  src6;
   logic [7:0]  src7;
   logic [8:0]  src8;
   logic [9:0]  src9;
   logic [10:0] src10;
   logic [11:0] src11;
   logic [12:0] src12;
   logic [11:0] src13;
   logic [10:0] src14;
   logic [9:0]  src15;
   logic [8:0]  src16;
   logic [7:0]  src17;
   logic [6:0]  src18;
   logic [5:0]  src19;
   logic [4:0]  src20;
   logic [3:0]  src21;
   logic [2:0]  src22;
   logic [1:0]  src23;
   logic        src24;
   logic dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9, dst10, dst11, dst12, dst13;
   logic dst14, dst15, dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23, dst24, dst25, dst26;
   logic [26:0] dst_v;

   assign {src24, src23, src22, src21, src20, src19, src18, src17, src16,
           src15, src14, src13, src12, src11, src10, src9,  src8,  src7,
           src6,  src5,  src4,  src3,  src2,  src1,  src0} = pp;

   assign dst_v = {dst26, dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18,
                   dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,
                   dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

   mul13_compressor u_dut (
      .clk(clk), .rst(rst),
      .src0(src0), .src1(src1), .src2(src2), .src3(src3), .src4(src4), .src5(src5),
      .src6(src6), .src7(src7), .src8(src8), .src9(src9), .src10(src10), .src11(src11),
      .src12(src12), .src13(src13), .src14(src14), .src15(src15), .src16(src16),
      .src17(src17), .src18(src18), .src19(src19), .src20(src20), .src21(src21),
      .src22(src22), .src23(src23), .src24(src24),
      .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3), .dst4(dst4), .dst5(dst5),
      .dst6(dst6), .dst7(dst7), .dst8(dst8), .dst9(dst9), .dst10(dst10), .dst11(dst11),
      .dst12(dst12), .dst13(dst13), .dst14(dst14), .dst15(dst15), .dst16(dst16),
      .dst17(dst17), .dst18(dst18), .dst19(dst19), .dst20(dst20), .dst21(dst21),
      .dst22(dst22), .dst23(dst23), .dst24(dst24), .dst25(dst25), .dst26(dst26)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [26:0] s1_exp  = '0;

   task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] exp_v);
      n_tests++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp_v);
      end
   endtask

   function automatic int height(input int c);
      return (c < 13) ? c + 1 : 25 - c;
   endfunction

   function automatic int base(input int c);
      int s = 0;
      for (int j = 0; j < c; j++) s += height(j);
      return s;
   endfunction

   // Reference: weighted sum of per-column popcounts
   function automatic logic [26:0] model(input logic [168:0] v);
      logic [26:0] sum = '0;
      int          off = 0;
      for (int c = 0; c < 25; c++) begin
         int cnt = 0;
         for (int b = 0; b < height(c); b++) cnt += int'(v[off+b]);
         sum += 27'(cnt) << c;
         off += height(c);
      end
      return sum;
   endfunction

   function automatic logic [168:0] pp_of(input logic [12:0] a, input logic [12:0] b);
      logic [168:0] v = '0;
      int           fill[25];
      for (int c = 0; c < 25; c++) fill[c] = 0;
      for (int j = 0; j < 13; j++)
         for (int k = 0; k < 13; k++) begin
            v[base(j + k) + fill[j+k]] = a[j] & b[k];
            fill[j+k]++;
         end
      return v;
   endfunction

   function automatic logic [168:0] rand_vec();
      logic [191:0] w;
      for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
      return w[168:0];
   endfunction

   // Apply one operand set for one clock; the value leaving the pipe is the one
   // that entered on the previous edge.
   task automatic cycle(input string tag, input logic [168:0] v, input logic [26:0] exp_v);
      pp = v;
      @(posedge clk);
      #1;
      chk(tag, dst_v, s1_exp);
      s1_exp = exp_v;
   endtask

   logic [168:0] v;
   logic [12:0]  a, b;

   initial begin
      // Reset held with toggling inputs
      for (int i = 0; i < 4; i++) begin
         pp = rand_vec();
         @(posedge clk);
         #1;
         chk("rst_hold", dst_v, 27'd0);
      end
      rst    = 1'b0;
      s1_exp = '0;

      v = '0; v[0] = 1'b1;
      cycle("rel_src0", v, model(v));
      cycle("rel_src0", '0, 27'd0);
      chk("rel_src0_val", dst_v, 27'd1);

      v = '0; v[base(12) +: 13] = 13'h1FFF;
      cycle("col12", v, 27'd53248);
      v = '0; v[168] = 1'b1;
      cycle("col24", v, 27'd16777216);
      v = '1;
      cycle("full", v, 27'h3FFC001);
      cycle("flush", '0, 27'd0);
      cycle("flush", '0, 27'd0);
      chk("full_top2", {25'd0, dst_v[26:25]}, 27'd0);
      cycle("flush", '0, 27'd0);

      v = pp_of(13'h1FFF, 13'h1FFF); cycle("mul_max", v, 27'(13'h1FFF) * 27'(13'h1FFF));
      v = pp_of(13'h1234, 13'h0ABC); cycle("mul_dir", v, 27'(13'h1234) * 27'(13'h0ABC));
      v = pp_of(13'h0001, 13'h0000); cycle("mul_zero", v, 27'd0);
      for (int i = 0; i < 10000; i++) begin
         a = 13'($urandom);
         b = 13'($urandom);
         cycle("mul_rand", pp_of(a, b), 27'(a) * 27'(b));
      end

      for (int i = 0; i < 20; i++) begin
         v = rand_vec();
         cycle("stream", v, model(v));
      end

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 5; i++) begin
         v = rand_vec();
         cycle("pre_rst", v, model(v));
      end
      rst = 1'b1;
      #1;
      chk("rst_async", dst_v, 27'd0);
      @(posedge clk);
      #1;
      chk("rst_edge", dst_v, 27'd0);
      rst    = 1'b0;
      s1_exp = '0;
      for (int i = 0; i < 20; i++) begin
         v = rand_vec();
         cycle("post_rst", v, model(v));
      end
      cycle("drain", '0, 27'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
